bcd_conv_arbiter: RTL

Sequential, shared binary-to-BCD converter with a built-in arbiter. Up to `N_REQ` requesters each present an 8-bit unsigned value. The block grants one requester at a time and runs double-dabble one bit per clock. It then returns hundreds/tens/units digits tagged with the winning requester's index. It sits between the core's debug/display sources (register file, PC, I/O) and the 7-segment display driver, replacing per-source combinational converters.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_dabble_step.sv | 30 +++
 rtl/bcd_conv_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The build option BCD_ARB_FIXED_PRIO_EN is consumed by bcd_conv_arbiter.
package bcd_pkg;

  localparam int BCD_IN_W  = 8;
  localparam int BCD_STEPS = 8;
  localparam int BCD_CNT_W = $clog2(BCD_STEPS);

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Double-dabble correction: a digit of 5 or more gets +3 so the next
  // shift carries correctly into the digit above (4-bit wrap, no carry out).
  function automatic bcd_digit_t bcd_add3(input bcd_digit_t d);
    return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step: add-3 correction on each digit,
// then shift the three digits left by one with a new binary bit entering
// the units digit.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  bcd_digit_t hund_i,
  input  bcd_digit_t tens_i,
  input  bcd_digit_t unit_i,
  input  logic       bit_i,
  output bcd_digit_t hund_o,
  output bcd_digit_t tens_o,
  output bcd_digit_t unit_o
);

  bcd_digit_t hund_adj;
  bcd_digit_t tens_adj;
  bcd_digit_t unit_adj;

  // Correct every digit first, then shift the whole chain left by one.
  always_comb begin
    hund_adj = bcd_add3(hund_i);
    tens_adj = bcd_add3(tens_i);
    unit_adj = bcd_add3(unit_i);
    hund_o   = {hund_adj[2:0], tens_adj[3]};
    tens_o   = {tens_adj[2:0], unit_adj[3]};
    unit_o   = {unit_adj[2:0], bit_i};
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shared binary-to-BCD converter with a built-in requester arbiter.
// Arbitration is round-robin by default; defining BCD_ARB_FIXED_PRIO_EN
// selects fixed priority (lowest index wins) and removes last_gnt.
//
// Handshake: a requester holds req_valid/req_data until it sees req_ack,
// which pulses for one cycle in IDLE; data is captured on that clock edge.
// Results appear as a one-cycle res_valid pulse with digits and res_id
// registered; digits hold until the next result.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [8*N_REQ-1:0]    req_data,
  output logic [N_REQ-1:0]      req_ack,
  output logic                  busy,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic [3:0]            centena,
  output logic [3:0]            dezena,
  output logic [3:0]            unidade,
  output bcd_state_t            dbg_state
);

  bcd_state_t              state_q;
  logic [BCD_CNT_W-1:0]    cnt_q;
  logic [BCD_IN_W-1:0]     shreg_q;
  bcd_digit_t              wh_q, wt_q, wu_q;
  bcd_digit_t              oh_q, ot_q, ou_q;
  logic                    res_valid_q;
  logic [ID_W-1:0]         res_id_q;
  bcd_digit_t              step_h, step_t, step_u;
  logic                    gnt_found;
  logic [ID_W-1:0]         gnt_idx;
  logic [ID_W-1:0]         cand;
  logic [BCD_IN_W-1:0]     data_arr [N_REQ];

`ifndef BCD_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]         last_gnt_q;
`endif

  // Unpack the flat request data bus into one byte per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[8*g +: 8];
  end

`ifdef BCD_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest valid index wins last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ID_W'(i);
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
`else
  // Round-robin: scan offsets from far to near so the requester closest
  // after last_gnt wins last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_gnt_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end
`endif

  // Acknowledge the winner combinationally, only while idle.
  always_comb begin
    req_ack = '0;
    if (state_q == IDLE && gnt_found) req_ack[gnt_idx] = 1'b1;
  end

  bcd_dabble_step u_step (
    .hund_i (wh_q),
    .tens_i (wt_q),
    .unit_i (wu_q),
    .bit_i  (shreg_q[BCD_IN_W-1]),
    .hund_o (step_h),
    .tens_o (step_t),
    .unit_o (step_u)
  );

  // Control FSM with datapath and output registers. The final SHIFT edge
  // loads the output digits and res_valid so they are visible during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      wh_q        <= '0;
      wt_q        <= '0;
      wu_q        <= '0;
      oh_q        <= '0;
      ot_q        <= '0;
      ou_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
`ifndef BCD_ARB_FIXED_PRIO_EN
      last_gnt_q  <= ID_W'(N_REQ - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          res_valid_q <= 1'b0;
          if (gnt_found) begin
            shreg_q    <= data_arr[gnt_idx];
            res_id_q   <= gnt_idx;
`ifndef BCD_ARB_FIXED_PRIO_EN
            last_gnt_q <= gnt_idx;
`endif
            wh_q       <= '0;
            wt_q       <= '0;
            wu_q       <= '0;
            cnt_q      <= BCD_CNT_W'(BCD_STEPS - 1);
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          wh_q    <= step_h;
          wt_q    <= step_t;
          wu_q    <= step_u;
          shreg_q <= {shreg_q[BCD_IN_W-2:0], 1'b0};
          if (cnt_q == '0) begin
            oh_q        <= step_h;
            ot_q        <= step_t;
            ou_q        <= step_u;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign centena   = oh_q;
  assign dezena    = ot_q;
  assign unidade   = ou_q;
  assign dbg_state = state_q;

endmodule
